// File: rtl/ifu_fetch.sv
// Instruction fetch unit: walks the fetch PC, issues one word read at a time and
// queues returned instructions with their PCs for the decode stage.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;

  assign mem_req_valid = !rst && (state == ST_REQ) && (count < DEPTH_CNT) && !redirect_valid;
  assign mem_req_addr  = fetch_pc;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

  // A redirect cancels both queue operations in its cycle.
  assign push = !redirect_valid && (state == ST_WAIT) && mem_resp_valid;
  assign pop  = !redirect_valid && inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      // The outstanding read, if still unanswered, must be swallowed later.
      case (state)
        ST_WAIT: state <= mem_resp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state <= mem_resp_valid ? ST_REQ : ST_DROP;
        default: state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (mem_req_valid && mem_req_ready) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: if (mem_resp_valid) state <= ST_REQ;
        ST_DROP: if (mem_resp_valid) state <= ST_REQ;
        default: state <= ST_REQ;
      endcase

      if (push) begin
        fifo_data[wr_ptr] <= mem_resp_data;
        fifo_pc[wr_ptr]   <= req_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
